// File: rtl/delay_line_pipe.sv
// Run-time selectable delay line: a WIDTH-bit word plus valid, delayed by 0..MAX_DEPTH enabled stages.
// Optional macro DELAY_LINE_OCC_EN adds the occ port (registered count of valid words in the line).
module delay_line_pipe #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 4,
  parameter int SELW      = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [SELW-1:0]  dly_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef DELAY_LINE_OCC_EN
  ,
  output logic [SELW-1:0]  occ
`endif
);

  // Valid-only stream: a word is taken on every enabled edge and leaves through
  // the selected tap; there is no ready, nothing backpressures, and words falling
  // off the last stage are dropped.

  localparam logic [SELW-1:0] MAX_SEL = SELW'(MAX_DEPTH);

  logic [MAX_DEPTH:1] v_q, v_d;
  logic [WIDTH-1:0]   d_q [1:MAX_DEPTH];
  logic [WIDTH-1:0]   d_d [1:MAX_DEPTH];
  logic [SELW-1:0]    eff;
  logic               tap_v;
  logic [WIDTH-1:0]   tap_d;

  // Flush only clears valids; data bits are left where they are.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else if (en) begin
      v_d[1] = in_valid;
      d_d[1] = in_data;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign eff = (dly_sel > MAX_SEL) ? MAX_SEL : dly_sel;

  // eff == 0 falls through to the combinational bypass.
  always_comb begin
    tap_v = in_valid;
    tap_d = in_data;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (eff == SELW'(k)) begin
        tap_v = v_q[k];
        tap_d = d_q[k];
      end
    end
  end

  assign out_valid = tap_v;
  assign out_data  = tap_v ? tap_d : '0;

`ifdef DELAY_LINE_OCC_EN
  logic [SELW-1:0] occ_q, occ_d;

  // Tracks valids entering s[1] and leaving s[MAX_DEPTH]; bounded by construction.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + SELW'(in_valid) - SELW'(v_q[MAX_DEPTH]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_delay_line_pipe.sv
// Bench for delay_line_pipe: directed scenarios then random traffic against a queue-based model.
module tb_delay_line_pipe;
  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 4;
  localparam int SELW      = $clog2(MAX_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic [SELW-1:0]  dly_sel;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef DELAY_LINE_OCC_EN
  logic [SELW-1:0]  occ;
`endif

  // Model: exp_q[0] is the word accepted on the most recent enabled edge, {valid, data}.
  logic [WIDTH:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  delay_line_pipe #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .dly_sel  (dly_sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data)
`ifdef DELAY_LINE_OCC_EN
    ,
    .occ      (occ)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  // Apply this edge's effect to the model (inputs are stable until the edge), then advance.
  task automatic tick();
    if (!rst) begin
      if (flush) begin
        for (int i = 0; i < exp_q.size(); i++) exp_q[i] = {1'b0, exp_q[i][WIDTH-1:0]};
      end else if (en) begin
        exp_q.push_front({in_valid, in_data});
        if (exp_q.size() > MAX_DEPTH) void'(exp_q.pop_back());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag);
    logic             exp_v;
    logic [WIDTH-1:0] exp_d;
    int               e;
`ifdef DELAY_LINE_OCC_EN
    int               cnt;
`endif
    #1;
    e     = (int'(dly_sel) > MAX_DEPTH) ? MAX_DEPTH : int'(dly_sel);
    exp_v = 1'b0;
    exp_d = '0;
    if (e == 0) begin
      exp_v = in_valid;
      exp_d = in_valid ? in_data : '0;
    end else if (e <= exp_q.size() && exp_q[e-1][WIDTH]) begin
      exp_v = 1'b1;
      exp_d = exp_q[e-1][WIDTH-1:0];
    end
    n_cmp++;
    assert (out_valid === exp_v) else begin
      n_fail++;
      $error("FAIL %s out_valid got %b expected %b", tag, out_valid, exp_v);
    end
    n_cmp++;
    assert (out_data === exp_d) else begin
      n_fail++;
      $error("FAIL %s out_data got %h expected %h", tag, out_data, exp_d);
    end
`ifdef DELAY_LINE_OCC_EN
    cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i][WIDTH]) cnt++;
    n_cmp++;
    assert (occ === SELW'(cnt)) else begin
      n_fail++;
      $error("FAIL %s occ got %0d expected %0d", tag, occ, cnt);
    end
`endif
  endtask

  task automatic check_const(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] w;
`ifdef DELAY_LINE_OCC_EN
    int occ_up[5] = '{1, 2, 3, 4, 4};
`endif
    // Reset with a held valid input on dly_sel=2
    rst = 1'b1; en = 1'b1; flush = 1'b0; dly_sel = SELW'(2);
    drive(1'b1, 8'hA5);
    exp_q.delete();
    #2;
    check("t1_rst0");
    repeat (3) begin
      tick();
      check("t1_rst");
      check_const("t1_rst_v", WIDTH'(out_valid), 8'h00);
    end
    rst = 1'b0;
    check("t1_rel");
    tick();
    check("t1_e1");
    check_const("t1_e1_v", WIDTH'(out_valid), 8'h00);
    tick();
    check("t1_e2");
    check_const("t1_e2_d", out_data, 8'hA5);

    // Latency 3
    dly_sel = SELW'(3);
    drive(1'b1, 8'h11); check("t2_in1"); tick();
    drive(1'b1, 8'h22); check("t2_in2"); tick();
    drive(1'b1, 8'h33); check("t2_in3"); tick();
    drive(1'b0, 8'h00);
    check("t2_e3"); check_const("t2_e3_d", out_data, 8'h11); tick();
    check("t2_e4"); check_const("t2_e4_d", out_data, 8'h22); tick();
    check("t2_e5"); check_const("t2_e5_d", out_data, 8'h33); tick();
    check("t2_e6"); check_const("t2_e6_v", WIDTH'(out_valid), 8'h00);
    check_const("t2_e6_d", out_data, 8'h00);

    // Stall
    repeat (4) tick();
    dly_sel = SELW'(2);
    drive(1'b1, 8'h5A); check("t3_in"); tick();
    drive(1'b0, 8'h00); en = 1'b0;
    repeat (3) begin
      check("t3_stall");
      check_const("t3_stall_v", WIDTH'(out_valid), 8'h00);
      tick();
    end
    en = 1'b1;
    check("t3_resume");
    tick();
    check("t3_out"); check_const("t3_out_d", out_data, 8'h5A);

    // Flush with en=0 while a valid word is offered
    dly_sel = SELW'(4);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i)); check("t4_fill"); tick();
    end
    check("t4_full"); check_const("t4_full_d", out_data, 8'h01);
    flush = 1'b1; en = 1'b0; drive(1'b1, 8'hFF);
    check("t4_flush"); tick();
    flush = 1'b0; en = 1'b1; drive(1'b0, 8'h00);
    check("t4_post"); check_const("t4_post_v", WIDTH'(out_valid), 8'h00);
`ifdef DELAY_LINE_OCC_EN
    check_const("t4_occ", WIDTH'(occ), 8'h00);
`endif
    repeat (5) begin
      tick(); check("t4_drain"); check_const("t4_drain_v", WIDTH'(out_valid), 8'h00);
    end

    // Bypass and clamp
    dly_sel = SELW'(0);
    drive(1'b1, 8'h3C); check("t5_byp"); check_const("t5_byp_d", out_data, 8'h3C);
    drive(1'b0, 8'h3C); check("t5_byp0"); check_const("t5_byp0_d", out_data, 8'h00);
    dly_sel = SELW'(7);
    w = WIDTH'($urandom);
    drive(1'b1, w); check("t5_clamp_in"); tick();
    drive(1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      check("t5_clamp");
      if (i < 4) begin
        check_const("t5_clamp_v", WIDTH'(out_valid), 8'h00);
        tick();
      end else begin
        check_const("t5_clamp_d", out_data, w);
      end
    end

`ifdef DELAY_LINE_OCC_EN
    // Occupancy ramp up and down
    repeat (4) tick();
    dly_sel = SELW'(1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, WIDTH'($urandom)); tick();
      check("t6_up"); check_const("t6_up_occ", WIDTH'(occ), WIDTH'(occ_up[i]));
    end
    drive(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_dn"); check_const("t6_dn_occ", WIDTH'(occ), WIDTH'(3 - i));
    end
`endif

    // Random traffic including stalls, flushes, select changes and async resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b1;
        exp_q.delete();
        check("rnd_rst");
        tick();
        rst = 1'b0;
      end else begin
        en      = ($urandom_range(0, 3) != 0);
        flush   = ($urandom_range(0, 19) == 0);
        dly_sel = SELW'($urandom_range(0, 7));
        drive(1'($urandom_range(0, 1)), WIDTH'($urandom));
        check("rnd");
        tick();
      end
    end
    flush = 1'b0;
    en    = 1'b1;

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
